// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : pulse_stretcher
// Purpose  : Turns single-cycle strobes into a registered level pulse of
//            programmable length. Supports optional retrigger, a post-pulse
//            holdoff window and a one-cycle completion strobe.
// Ports    : clk      - system clock, rising edge
//            rst      - asynchronous active-high reset
//            strobe   - trigger sample (each high cycle is one sample)
//            len      - pulse length in cycles, taken on the accepted edge
//            signal   - stretched pulse (registered)
//            busy     - high whenever the block is not idle (registered)
//            done     - one-cycle pulse in the first cycle after signal falls
//            drop_clr - (optional) clears drop_cnt on the next edge
//            drop_cnt - (optional) saturating count of ignored strobes
// Options  : define PULSE_STRETCHER_DROP_CNT_EN to add drop_clr/drop_cnt
// Revision : 1.0 - initial release
// ============================================================================
module pulse_stretcher #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 2,
  parameter int RETRIGGER = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  logic [WIDTH-1:0] len,
  output logic             signal,
  output logic             busy,
  output logic             done
`ifdef PULSE_STRETCHER_DROP_CNT_EN
  ,
  input  logic             drop_clr,
  output logic [15:0]      drop_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_GAP     = WIDTH'(GAP);
  localparam logic             C_HAS_GAP = (GAP != 0);
  localparam logic             C_RETRIG  = (RETRIGGER != 0);

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nx;
  logic             r_signal;
  logic             w_signal_nx;
  logic             r_busy;
  logic             w_busy_nx;
  logic             r_done;
  logic             w_done_nx;
  logic             w_trig;

  // A trigger is only meaningful with a non-zero length.
  assign w_trig = strobe & (len != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_signal <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_signal <= w_signal_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_signal_nx = r_signal;
    w_done_nx   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_state_nx  = S_ACTIVE;
          w_cnt_nx    = len;
          w_signal_nx = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (C_RETRIG && w_trig) begin
          // Reload keeps signal high; this also covers the last active cycle.
          w_cnt_nx = len;
        end else if (r_cnt == WIDTH'(1)) begin
          w_signal_nx = 1'b0;
          w_done_nx   = 1'b1;
          if (C_HAS_GAP) begin
            w_state_nx = S_HOLDOFF;
            w_cnt_nx   = C_GAP;
          end else begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
          end
        end else begin
          w_cnt_nx = r_cnt - WIDTH'(1);
        end
      end
      S_HOLDOFF: begin
        // <= 1 guards against a GAP that truncated to zero in WIDTH bits.
        if (r_cnt <= WIDTH'(1)) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt - WIDTH'(1);
        end
      end
      default: begin
        w_state_nx  = S_IDLE;
        w_cnt_nx    = '0;
        w_signal_nx = 1'b0;
      end
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  assign signal = r_signal;
  assign busy   = r_busy;
  assign done   = r_done;

`ifdef PULSE_STRETCHER_DROP_CNT_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  // Strobes swallowed by a running pulse (no retrigger) or by holdoff.
  assign w_drop = strobe & (((r_state == S_ACTIVE) && !C_RETRIG) ||
                            (r_state == S_HOLDOFF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= 16'h0000;
    end else if (drop_clr) begin
      r_drop_cnt <= 16'h0000;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'h0001;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_stretcher
// Purpose  : Directed self-checking bench for pulse_stretcher. Four instances
//            cover GAP=2/RETRIGGER=0, GAP=2/RETRIGGER=1, GAP=3/RETRIGGER=0
//            and GAP=0/RETRIGGER=0; all share clock, reset and stimulus.
//            Waveform vectors index n hold the output value seen at edge n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_stretcher;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       strobe   = 1'b0;
  logic [7:0] len      = 8'd0;
  logic       drop_clr = 1'b0;
  logic [3:0] sig;
  logic [3:0] bsy;
  logic [3:0] dn;
  logic [15:0] dc [4];

  int total = 0;
  int bad   = 0;

  logic [31:0] vs [4];
  logic [31:0] vb [4];
  logic [31:0] vd [4];

  always #5 clk = ~clk;

`ifdef PULSE_STRETCHER_DROP_CNT_EN
  pulse_stretcher #(.WIDTH(8), .GAP(2), .RETRIGGER(0)) u0 (
    .clk(clk), .rst(rst), .strobe(strobe), .len(len),
    .signal(sig[0]), .busy(bsy[0]), .done(dn[0]),
    .drop_clr(drop_clr), .drop_cnt(dc[0]));
  pulse_stretcher #(.WIDTH(8), .GAP(2), .RETRIGGER(1)) u1 (
    .clk(clk), .rst(rst), .strobe(strobe), .len(len),
    .signal(sig[1]), .busy(bsy[1]), .done(dn[1]),
    .drop_clr(drop_clr), .drop_cnt(dc[1]));
  pulse_stretcher #(.WIDTH(8), .GAP(3), .RETRIGGER(0)) u2 (
    .clk(clk), .rst(rst), .strobe(strobe), .len(len),
    .signal(sig[2]), .busy(bsy[2]), .done(dn[2]),
    .drop_clr(drop_clr), .drop_cnt(dc[2]));
  pulse_stretcher #(.WIDTH(8), .GAP(0), .RETRIGGER(0)) u3 (
    .clk(clk), .rst(rst), .strobe(strobe), .len(len),
    .signal(sig[3]), .busy(bsy[3]), .done(dn[3]),
    .drop_clr(drop_clr), .drop_cnt(dc[3]));
`else
  pulse_stretcher #(.WIDTH(8), .GAP(2), .RETRIGGER(0)) u0 (
    .clk(clk), .rst(rst), .strobe(strobe), .len(len),
    .signal(sig[0]), .busy(bsy[0]), .done(dn[0]));
  pulse_stretcher #(.WIDTH(8), .GAP(2), .RETRIGGER(1)) u1 (
    .clk(clk), .rst(rst), .strobe(strobe), .len(len),
    .signal(sig[1]), .busy(bsy[1]), .done(dn[1]));
  pulse_stretcher #(.WIDTH(8), .GAP(3), .RETRIGGER(0)) u2 (
    .clk(clk), .rst(rst), .strobe(strobe), .len(len),
    .signal(sig[2]), .busy(bsy[2]), .done(dn[2]));
  pulse_stretcher #(.WIDTH(8), .GAP(0), .RETRIGGER(0)) u3 (
    .clk(clk), .rst(rst), .strobe(strobe), .len(len),
    .signal(sig[3]), .busy(bsy[3]), .done(dn[3]));
  initial for (int i = 0; i < 4; i++) dc[i] = 16'h0000;
`endif

  // Drives strobe from pat (bit e is sampled at edge e) and records outputs.
  task automatic run(input int n, input logic [31:0] pat, input logic [7:0] l);
    for (int d = 0; d < 4; d++) begin
      vs[d] = '0; vb[d] = '0; vd[d] = '0;
    end
    for (int e = 0; e < n; e++) begin
      strobe = pat[e];
      len    = l;
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
        vs[d][e+1] = sig[d];
        vb[d][e+1] = bsy[d];
        vd[d][e+1] = dn[d];
      end
    end
    strobe = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1; strobe = 1'b0; len = 8'd0; drop_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({sig, bsy, dn} !== 12'h000) begin
      bad++; $display("FAIL reset_async: got %h want 000", {sig, bsy, dn});
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({sig, bsy, dn} !== 12'h000) begin
      bad++; $display("FAIL reset_held: got %h want 000", {sig, bsy, dn});
    end
`ifdef PULSE_STRETCHER_DROP_CNT_EN
    total++;
    if (dc[0] !== 16'h0000) begin
      bad++; $display("FAIL reset_drop_cnt: got %h want 0000", dc[0]);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    run(12, 32'h1, 8'd5);
    total++;
    if (vs[0] !== 32'h3E) begin bad++; $display("FAIL single_signal: got %h want 0000003e", vs[0]); end
    total++;
    if (vd[0] !== 32'h40) begin bad++; $display("FAIL single_done: got %h want 00000040", vd[0]); end
    total++;
    if (vb[0] !== 32'hFE) begin bad++; $display("FAIL single_busy: got %h want 000000fe", vb[0]); end
  endtask

  task automatic test_len_zero;
    do_reset();
    run(6, 32'h1, 8'd0);
    total++;
    if ((vs[0] | vb[0] | vd[0]) !== 32'h0) begin
      bad++; $display("FAIL len_zero_outputs: got %h want 00000000", vs[0] | vb[0] | vd[0]);
    end
`ifdef PULSE_STRETCHER_DROP_CNT_EN
    total++;
    if (dc[0] !== 16'h0000) begin bad++; $display("FAIL len_zero_drop: got %h want 0000", dc[0]); end
`endif
  endtask

  task automatic test_retrigger;
    do_reset();
    run(12, 32'h5, 8'd4);
    total++;
    if (vs[1] !== 32'h7E) begin bad++; $display("FAIL retrig_signal: got %h want 0000007e", vs[1]); end
    total++;
    if (vd[1] !== 32'h80) begin bad++; $display("FAIL retrig_done: got %h want 00000080", vd[1]); end
    total++;
    if (vb[1] !== 32'h1FE) begin bad++; $display("FAIL retrig_busy: got %h want 000001fe", vb[1]); end
    total++;
    if (vs[0] !== 32'h1E) begin bad++; $display("FAIL noretrig_signal: got %h want 0000001e", vs[0]); end
`ifdef PULSE_STRETCHER_DROP_CNT_EN
    total++;
    if (dc[0] !== 16'd1) begin bad++; $display("FAIL noretrig_drop: got %0d want 1", dc[0]); end
    total++;
    if (dc[1] !== 16'd0) begin bad++; $display("FAIL retrig_drop: got %0d want 0", dc[1]); end
`endif
  endtask

  task automatic test_retrigger_last;
    do_reset();
    run(14, 32'h11, 8'd4);
    total++;
    if (vs[1] !== 32'h1FE) begin bad++; $display("FAIL retrig_last_signal: got %h want 000001fe", vs[1]); end
    total++;
    if (vd[1] !== 32'h200) begin bad++; $display("FAIL retrig_last_done: got %h want 00000200", vd[1]); end
  endtask

  task automatic test_holdoff;
    do_reset();
    run(16, 32'hA5, 8'd3);
    total++;
    if (vs[2] !== 32'h70E) begin bad++; $display("FAIL holdoff_signal: got %h want 0000070e", vs[2]); end
    total++;
    if (vd[2] !== 32'h810) begin bad++; $display("FAIL holdoff_done: got %h want 00000810", vd[2]); end
    total++;
    if (vb[2] !== 32'h3F7E) begin bad++; $display("FAIL holdoff_busy: got %h want 00003f7e", vb[2]); end
`ifdef PULSE_STRETCHER_DROP_CNT_EN
    total++;
    if (dc[2] !== 16'd2) begin bad++; $display("FAIL holdoff_drop: got %0d want 2", dc[2]); end
`endif
  endtask

  task automatic test_async_reset;
    do_reset();
    len = 8'd10;
    strobe = 1'b1;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (sig[0] !== 1'b1) begin bad++; $display("FAIL midpulse_signal: got %b want 1", sig[0]); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({sig[0], bsy[0]} !== 2'b00) begin
      bad++; $display("FAIL async_drop: got %b want 00", {sig[0], bsy[0]});
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dn[0] !== 1'b0) begin bad++; $display("FAIL async_no_done: got %b want 0", dn[0]); end
    rst = 1'b0;
    run(14, 32'h1, 8'd10);
    total++;
    if (vs[0] !== 32'h7FE) begin bad++; $display("FAIL fresh_signal: got %h want 000007fe", vs[0]); end
    total++;
    if (vd[0] !== 32'h800) begin bad++; $display("FAIL fresh_done: got %h want 00000800", vd[0]); end
  endtask

  task automatic test_back_to_back;
    int errs;
    int exp_drops;
    logic exp_sig;
    errs = 0;
    exp_drops = 0;
    do_reset();
    len = 8'd2;
    strobe = 1'b1;
    // Period of 3 edges: accept, drop (running), drop (falling edge).
    for (int e = 0; e < 300; e++) begin
      @(posedge clk);
      #1;
      exp_sig = ((e % 3) != 2);
      if ((e % 3) != 0) exp_drops++;
      if (sig[3] !== exp_sig) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL b2b_signal: got %0d bad cycles want 0", errs); end
`ifdef PULSE_STRETCHER_DROP_CNT_EN
    total++;
    if (dc[3] !== 16'(exp_drops)) begin
      bad++; $display("FAIL b2b_drop_cnt: got %0d want %0d", dc[3], exp_drops);
    end
    @(posedge clk);
    #1;
    drop_clr = 1'b1;
    @(posedge clk);
    #1;
    drop_clr = 1'b0;
    total++;
    if (dc[3] !== 16'd0) begin bad++; $display("FAIL clr_wins: got %0d want 0", dc[3]); end
    @(posedge clk);
    #1;
    total++;
    if (dc[3] !== 16'd1) begin bad++; $display("FAIL post_clr_count: got %0d want 1", dc[3]); end
`endif
    strobe = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_len_zero();
    test_retrigger();
    test_retrigger_last();
    test_holdoff();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
